// File: rtl/shake_fmt_pkg.sv
// Shared types for the digest formatter: lane width, conversion mode encodings
// and the collection FSM states.
package shake_fmt_pkg;

  localparam int LANE_W = 64;

  typedef enum logic [1:0] {
    MODE_NONE       = 2'd0,
    MODE_LANE_BSWAP = 2'd1,
    MODE_FULL_REV   = 2'd2,
    MODE_LANE_SWAP  = 2'd3
  } fmt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } fmt_state_e;

  // Lane counter must be able to hold N itself, hence the extra bit.
  function automatic int lane_cnt_w(input int n_lanes);
    return $clog2(n_lanes) + 1;
  endfunction

endpackage

// File: rtl/digest_reorder.sv
// Combinational byte/lane reordering of a collected digest according to the
// selected conversion mode.
module digest_reorder
  import shake_fmt_pkg::*;
#(
  parameter int OUT_BITS = 128
) (
  input  logic [OUT_BITS-1:0] i_data,
  input  fmt_mode_e           i_mode,
  output logic [OUT_BITS-1:0] o_data
);

  localparam int N  = OUT_BITS / LANE_W;
  localparam int NB = OUT_BITS / 8;

  function automatic logic [OUT_BITS-1:0] f_lane_bswap(input logic [OUT_BITS-1:0] d);
    logic [OUT_BITS-1:0] r;
    r = {OUT_BITS{1'b0}};
    for (int l = 0; l < N; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[l*LANE_W + b*8 +: 8] = d[l*LANE_W + (7-b)*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [OUT_BITS-1:0] f_full_rev(input logic [OUT_BITS-1:0] d);
    logic [OUT_BITS-1:0] r;
    r = {OUT_BITS{1'b0}};
    for (int b = 0; b < NB; b++) begin
      r[b*8 +: 8] = d[(NB-1-b)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [OUT_BITS-1:0] f_lane_swap(input logic [OUT_BITS-1:0] d);
    logic [OUT_BITS-1:0] r;
    r = {OUT_BITS{1'b0}};
    for (int l = 0; l < N; l++) begin
      r[l*LANE_W +: LANE_W] = d[(N-1-l)*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  // Select the conversion for the current mode.
  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_NONE:       o_data = i_data;
      MODE_LANE_BSWAP: o_data = f_lane_bswap(i_data);
      MODE_FULL_REV:   o_data = f_full_rev(i_data);
      MODE_LANE_SWAP:  o_data = f_lane_swap(i_data);
      default:         o_data = i_data;
    endcase
  end

endmodule

// File: rtl/digest_formatter.sv
// Collects N = OUT_BITS/64 squeezed lanes into a digest and emits it reordered.
// Define DIGEST_FMT_FRAME_CHECK_EN to enable in_last framing-error pulses on err.
module digest_formatter
  import shake_fmt_pkg::*;
#(
  parameter int         OUT_BITS = 128,
  parameter logic [1:0] DEF_MODE = 2'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                mode_ovr,
  input  logic [LANE_W-1:0]   in_lane,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err
);

  localparam int N     = OUT_BITS / LANE_W;
  localparam int CNT_W = lane_cnt_w(N);

  fmt_state_e          r_state;
  fmt_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_BITS-1:0] r_buf;
  fmt_mode_e           r_mode;
  logic [OUT_BITS-1:0] r_out_data;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_err;

  fmt_mode_e           w_eff_mode;
  fmt_mode_e           w_mode_use;
  logic                w_accept;
  logic                w_first_lane;
  logic                w_last_lane;
  logic                w_out_fire;
  logic [OUT_BITS-1:0] w_buf_nxt;
  logic [OUT_BITS-1:0] w_conv;

  assign w_eff_mode   = mode_ovr ? fmt_mode_e'(mode) : fmt_mode_e'(DEF_MODE);
  assign w_accept     = in_valid & r_in_ready;
  assign w_first_lane = (r_cnt == CNT_W'(0));
  assign w_last_lane  = (r_cnt == CNT_W'(N-1));
  assign w_out_fire   = r_out_valid & out_ready;
  // Lane 0 is converted with the mode being latched on that same edge (N=1 case).
  assign w_mode_use   = w_first_lane ? w_eff_mode : r_mode;

  // Buffer image including the lane arriving this cycle, so the last lane needs no extra cycle.
  always_comb begin
    w_buf_nxt = r_buf;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_buf_nxt[k*LANE_W +: LANE_W] = in_lane;
      end else begin
        w_buf_nxt[k*LANE_W +: LANE_W] = r_buf[k*LANE_W +: LANE_W];
      end
    end
  end

  digest_reorder #(
    .OUT_BITS (OUT_BITS)
  ) u_reorder (
    .i_data (w_buf_nxt),
    .i_mode (w_mode_use),
    .o_data (w_conv)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_last_lane) begin
          w_state_nxt = ST_HOLD;
        end else if (w_accept) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (w_accept && w_last_lane) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (w_out_fire) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane buffer, counter, latched mode and registered output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= CNT_W'(0);
      r_buf       <= {OUT_BITS{1'b0}};
      r_mode      <= fmt_mode_e'(DEF_MODE);
      r_out_data  <= {OUT_BITS{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != ST_HOLD);
      if (w_accept) begin
        r_buf <= w_buf_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_first_lane) begin
          r_mode <= w_eff_mode;
        end
        if (w_last_lane) begin
          r_out_data  <= w_conv;
          r_out_valid <= 1'b1;
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_cnt       <= CNT_W'(0);
      end
    end
  end

`ifdef DIGEST_FMT_FRAME_CHECK_EN
  // Flag lanes whose in_last marker disagrees with their position in the digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & (in_last != w_last_lane);
    end
  end
`else
  logic w_unused;
  assign w_unused = in_last;

  // Framing check disabled: err is held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
    end
  end
`endif

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_digest_formatter.sv
// Directed bench for digest_formatter with OUT_BITS=128 (two lanes per digest).
module tb_digest_formatter;

  logic         clk;
  logic         rst;
  logic [1:0]   mode;
  logic         mode_ovr;
  logic [63:0]  in_lane;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

`ifdef DIGEST_FMT_FRAME_CHECK_EN
  localparam logic FRAME_EN = 1'b1;
`else
  localparam logic FRAME_EN = 1'b0;
`endif

  localparam logic [63:0]  L0    = 64'h0706050403020100;
  localparam logic [63:0]  L1    = 64'h0F0E0D0C0B0A0908;
  localparam logic [127:0] EXP_M0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] EXP_M1 = 128'h08090A0B0C0D0E0F0001020304050607;
  localparam logic [127:0] EXP_M2 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] EXP_M3 = 128'h07060504030201000F0E0D0C0B0A0908;
  localparam logic [63:0]  LA    = 64'h1122334455667788;
  localparam logic [63:0]  LB    = 64'h99AABBCCDDEEFF00;
  localparam logic [127:0] EXP_AB = 128'h99AABBCCDDEEFF001122334455667788;

  digest_formatter #(
    .OUT_BITS (128),
    .DEF_MODE (2'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .mode_ovr  (mode_ovr),
    .in_lane   (in_lane),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lane(input logic [63:0] lane, input logic last);
    in_valid = 1'b1;
    in_lane  = lane;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_digest(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [127:0] exp);
    out_ready = 1'b0;
    send_lane(a, 1'b0);
    check({tag, "_nv_after_lane0"}, {127'd0, out_valid}, 128'd0);
    send_lane(b, 1'b1);
    check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_rdy_hold"}, {127'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    step();
    check({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    check({tag, "_rdy_idle"}, {127'd0, in_ready}, 128'd1);
    check({tag, "_data_kept"}, out_data, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd0;
    mode_ovr  = 1'b0;
    in_lane   = 64'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Conversion modes: default (mode_ovr=0) then override modes 1..3
    run_digest("m0", L0, L1, EXP_M0);
    mode_ovr = 1'b1;
    mode = 2'd1;
    run_digest("m1", L0, L1, EXP_M1);
    mode = 2'd2;
    run_digest("m2", L0, L1, EXP_M2);
    mode = 2'd3;
    run_digest("m3", L0, L1, EXP_M3);
    check("no_err_normal", {127'd0, err}, 128'd0);

    // Backpressure: 5 stalled cycles with junk offered upstream, accepted on the 6th
    mode_ovr = 1'b0;
    send_lane(L0, 1'b0);
    send_lane(L1, 1'b1);
    check("bp_valid", {127'd0, out_valid}, 128'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_lane  = 64'hDEADBEEFDEADBEEF;
      step();
      check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
      check("bp_hold_data", out_data, EXP_M0);
      check("bp_hold_rdy", {127'd0, in_ready}, 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_valid", {127'd0, out_valid}, 128'd0);
    check("bp_release_rdy", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b0;
    run_digest("bp_next", LA, LB, EXP_AB);

    // Mode change after lane 0 must not affect the digest in flight
    mode_ovr = 1'b1;
    mode = 2'd1;
    send_lane(L0, 1'b0);
    mode = 2'd2;
    send_lane(L1, 1'b1);
    check("mtog_valid", {127'd0, out_valid}, 128'd1);
    check("mtog_data", out_data, EXP_M1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    mode_ovr = 1'b0;

    // Reset after lane 0 discards the partial digest
    send_lane(L0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_valid", {127'd0, out_valid}, 128'd0);
    check("mrst_rdy", {127'd0, in_ready}, 128'd0);
    check("mrst_data", out_data, 128'd0);
    step();
    rst = 1'b0;
    step();
    check("mrst_rdy_back", {127'd0, in_ready}, 128'd1);
    check("mrst_still_nv", {127'd0, out_valid}, 128'd0);
    run_digest("mrst_fresh", LA, LB, EXP_AB);

    // Framing: in_last on lane 0 of a two-lane digest
    send_lane(L0, 1'b1);
    check("frame_err_pulse", {127'd0, err}, {127'd0, FRAME_EN});
    send_lane(L1, 1'b1);
    check("frame_err_clear", {127'd0, err}, 128'd0);
    check("frame_valid", {127'd0, out_valid}, 128'd1);
    check("frame_data", out_data, EXP_M0);
    out_ready = 1'b1;
    step();
    check("frame_done", {127'd0, out_valid}, 128'd0);
    check("frame_err_idle", {127'd0, err}, 128'd0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
